// File: rtl/encoder_sample_if.sv
// Sample channel from the step accumulator to the readout logic:
// a {position, delta, saturated} record moved with a valid/ready handshake.
interface encoder_sample_if #(
  parameter int POS_W   = 16,
  parameter int DELTA_W = 8
);
  // Handshake: a sample transfers on any clock edge where out_valid and
  // out_ready are both 1. While out_valid=1 and out_ready=0 the payload
  // holds steady. out_valid never waits on out_ready, and out_ready may be
  // driven high at any time, including when out_valid=0.
  logic               out_valid;
  logic               out_ready;
  logic [POS_W-1:0]   out_pos;
  logic [DELTA_W-1:0] out_delta;
  logic               out_sat;

  modport master (
    output out_valid,
    output out_pos,
    output out_delta,
    output out_sat,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_pos,
    input  out_delta,
    input  out_sat,
    output out_ready
  );
endinterface

// File: rtl/encoder_step_accum.sv
// Accumulates decoded encoder steps into a wrapping position and a saturating
// per-window delta, and queues one sample per window in a 2-entry buffer.
module encoder_step_accum #(
  parameter int POS_W   = 16,
  parameter int DELTA_W = 8,
  parameter int WINDOW  = 1000
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               clear,
  input  logic               step_valid,
  input  logic               step_dir,
  output logic [POS_W-1:0]   pos_o,
  output logic               overrun,
  encoder_sample_if.master   smp
);

  localparam int                 WIN_W    = $clog2(WINDOW);
  localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [DELTA_W-1:0] D_MAX    = {1'b0, {(DELTA_W-1){1'b1}}};
  localparam logic [DELTA_W-1:0] D_MIN    = {1'b1, {(DELTA_W-1){1'b0}}};

  logic [POS_W-1:0]   pos_q, pos_d;
  logic [DELTA_W-1:0] delta_q, delta_d;
  logic               sat_q, sat_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [POS_W-1:0]   buf_pos_q [0:1];
  logic [POS_W-1:0]   buf_pos_d [0:1];
  logic [DELTA_W-1:0] buf_delta_q [0:1];
  logic [DELTA_W-1:0] buf_delta_d [0:1];
  logic [1:0]         buf_sat_q, buf_sat_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               overrun_q, overrun_d;

  logic               step, terminal, pop, push_ok;
  logic [POS_W-1:0]   smp_pos;
  logic [DELTA_W-1:0] smp_delta;
  logic               smp_sat;

  always_comb begin
    pos_d       = pos_q;
    delta_d     = delta_q;
    sat_d       = sat_q;
    win_d       = win_q;
    buf_pos_d   = buf_pos_q;
    buf_delta_d = buf_delta_q;
    buf_sat_d   = buf_sat_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    overrun_d   = overrun_q;

    step     = step_valid & enable;
    terminal = enable & (win_q == WIN_LAST);
    pop      = (cnt_q != 2'd0) & smp.out_ready;
    push_ok  = terminal & ((cnt_q != 2'd2) | pop);

    // Post-step values; these are also the sample taken on a terminal cycle.
    smp_pos   = pos_q;
    smp_delta = delta_q;
    smp_sat   = sat_q;
    if (step) begin
      smp_pos = step_dir ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
      if ((step_dir && delta_q == D_MAX) || (!step_dir && delta_q == D_MIN)) begin
        smp_sat = 1'b1;
      end else begin
        smp_delta = step_dir ? delta_q + DELTA_W'(1) : delta_q - DELTA_W'(1);
      end
    end

    if (clear) begin
      pos_d       = '0;
      delta_d     = '0;
      sat_d       = 1'b0;
      win_d       = '0;
      buf_pos_d   = '{default: '0};
      buf_delta_d = '{default: '0};
      buf_sat_d   = '0;
      rd_ptr_d    = 1'b0;
      wr_ptr_d    = 1'b0;
      cnt_d       = 2'd0;
      overrun_d   = 1'b0;
    end else begin
      pos_d   = smp_pos;
      delta_d = terminal ? '0 : smp_delta;
      sat_d   = terminal ? 1'b0 : smp_sat;
      if (enable) begin
        win_d = terminal ? '0 : win_q + WIN_W'(1);
      end
      if (terminal && !push_ok) begin
        overrun_d = 1'b1;
      end
      // When full, wr_ptr equals rd_ptr: a coincident pop frees the very slot written.
      if (push_ok) begin
        buf_pos_d[wr_ptr_q]   = smp_pos;
        buf_delta_d[wr_ptr_q] = smp_delta;
        buf_sat_d[wr_ptr_q]   = smp_sat;
        wr_ptr_d              = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push_ok, pop})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pos_q       <= '0;
      delta_q     <= '0;
      sat_q       <= 1'b0;
      win_q       <= '0;
      buf_pos_q   <= '{default: '0};
      buf_delta_q <= '{default: '0};
      buf_sat_q   <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
      overrun_q   <= 1'b0;
    end else begin
      pos_q       <= pos_d;
      delta_q     <= delta_d;
      sat_q       <= sat_d;
      win_q       <= win_d;
      buf_pos_q   <= buf_pos_d;
      buf_delta_q <= buf_delta_d;
      buf_sat_q   <= buf_sat_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  assign pos_o         = pos_q;
  assign overrun       = overrun_q;
  assign smp.out_valid = (cnt_q != 2'd0);
  assign smp.out_pos   = buf_pos_q[rd_ptr_q];
  assign smp.out_delta = buf_delta_q[rd_ptr_q];
  assign smp.out_sat   = buf_sat_q[rd_ptr_q];

endmodule
